// File: rtl/bit_serializer.sv
// bit_serializer: word-to-bit serializer, one-word skid (hold) buffer.
// Ports: clk, res (sync, active-low), in_valid/in_data/in_ready (word in),
//   valid/d_in (serial bit out), busy, words_sent (16-bit wrap count).
// Option: define SER_PAUSE_EN to add input pause (stalls the bit stream).
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             res,
`ifdef SER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             valid,
  output logic             d_in,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             stall;
  logic             accept;
  logic             last;

`ifdef SER_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  function automatic logic lead(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = !hold_full && res;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST);
  assign busy     = (state == SHIFT) || hold_full;

  // sh always holds the bit on d_in at its lead position. A bit is
  // consumed only on an edge where it was shown (valid=1); while valid
  // is low after a pause the next bit waits in sh, so none is repeated.
  always_ff @(posedge clk) begin
    if (!res) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      valid      <= 1'b0;
      d_in       <= 1'b0;
      words_sent <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            sh    <= in_data;
            cnt   <= '0;
            valid <= !stall;
            d_in  <= lead(in_data);
          end
        end
        SHIFT: begin
          if (accept && !(valid && last)) begin
            hold      <= in_data;
            hold_full <= 1'b1;
          end
          if (!valid) begin
            valid <= !stall;
          end else if (!last) begin
            sh    <= adv(sh);
            cnt   <= cnt + CW'(1);
            d_in  <= lead(adv(sh));
            valid <= !stall;
          end else begin
            words_sent <= words_sent + 16'd1;
            if (hold_full) begin
              sh        <= hold;
              cnt       <= '0;
              d_in      <= lead(hold);
              valid     <= !stall;
              hold_full <= 1'b0;
            end else if (accept) begin
              sh    <= in_data;
              cnt   <= '0;
              d_in  <= lead(in_data);
              valid <= !stall;
            end else begin
              state <= IDLE;
              cnt   <= '0;
              valid <= 1'b0;
              d_in  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: MSB-first and LSB-first instances on shared inputs,
// checked every cycle against a bit-queue model of the serial stream.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
`ifdef SER_PAUSE_EN
  logic         pause = 1'b0;
`endif
  logic         rdy0, rdy1, v0, v1, d0, d1, b0, b1;
  logic [15:0]  ws0, ws1;
  logic [37:0]  obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .res(res),
`ifdef SER_PAUSE_EN
    .pause(pause),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .valid(v0), .d_in(d0), .busy(b0), .words_sent(ws0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .res(res),
`ifdef SER_PAUSE_EN
    .pause(pause),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .valid(v1), .d_in(d1), .busy(b1), .words_sent(ws1)
  );

  assign obs = {v0, v1, rdy0, rdy1, b0, b1, ws0, ws1};

  // Model: queues of bits still to appear on each serial output.
  bit          q0[$];
  bit          q1[$];
  logic [15:0] m_ws = '0;
  int          popped = 0;
  bit          pz = 1'b0;
  bit          m_acc;

  always @(posedge clk) begin
    if (!res) begin
      q0.delete();
      q1.delete();
      m_ws   = '0;
      popped = 0;
      pz     = 1'b0;
    end else begin
      m_acc = in_valid && (q0.size() <= W);
      if (q0.size() > 0 && !pz) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        popped++;
        if (popped % W == 0) m_ws = m_ws + 16'd1;
      end
      if (m_acc) begin
        for (int i = 0; i < W; i++) begin
          q0.push_back(in_data[W-1-i]);
          q1.push_back(in_data[i]);
        end
      end
`ifdef SER_PAUSE_EN
      pz = pause;
`endif
    end
  end

  function automatic logic [37:0] exp_vec();
    logic ev, er, eb;
    ev = (q0.size() > 0) && !pz;
    er = res && (q0.size() <= W);
    eb = (q0.size() > 0);
    return {ev, ev, er, er, eb, eb, m_ws, m_ws};
  endfunction

  function automatic bit d_known();
    return (q0.size() == 0) || !pz;
  endfunction

  function automatic logic [1:0] exp_d();
    if (q0.size() == 0) return 2'b00;
    return {q0[0], q1[0]};
  endfunction

  task automatic test_reset();
    res = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      checks++;
      if ({d0, d1} !== 2'b00) begin
        errors++;
        $display("FAIL reset d_in t=%0t got %b exp 00", $time, {d0, d1});
      end
    end
    @(negedge clk);
    res = 1'b1;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errors++;
      $display("FAIL reset release in_ready got %b exp 11", {rdy0, rdy1});
    end
  endtask

  task automatic test_single();
    logic [7:0] c0, c1;
    int nv;
    c0 = '0;
    c1 = '0;
    nv = 0;
    in_valid = 1'b1;
    in_data  = 8'hD4;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL single d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      if (v0) begin
        c0 = {c0[6:0], d0};
        nv++;
      end
      if (v1) c1 = {c1[6:0], d1};
      in_valid = 1'b0;
    end
    checks++;
    if (c0 !== 8'hD4) begin
      errors++;
      $display("FAIL single msb bits got %h exp d4", c0);
    end
    checks++;
    if (c1 !== 8'h2B) begin
      errors++;
      $display("FAIL single lsb bits got %h exp 2b", c1);
    end
    checks++;
    if (nv != 8) begin
      errors++;
      $display("FAIL single valid_cycles got %0d exp 8", nv);
    end
    checks++;
    if (ws0 !== 16'd1) begin
      errors++;
      $display("FAIL single words_sent got %0d exp 1", ws0);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] c0, c1;
    c0 = '0;
    c1 = '0;
    in_valid = 1'b1;
    in_data  = 8'h2B;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL lsb ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL lsb d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      if (v0) c0 = {c0[6:0], d0};
      if (v1) c1 = {c1[6:0], d1};
      in_valid = 1'b0;
    end
    checks++;
    if (c1 !== 8'hD4) begin
      errors++;
      $display("FAIL lsb bits got %h exp d4", c1);
    end
    checks++;
    if (c0 !== 8'h2B) begin
      errors++;
      $display("FAIL lsb msb_bits got %h exp 2b", c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  wl[3];
    logic [15:0] ws_start;
    int idx, run, maxrun;
    bit take;
    wl = '{8'hD4, 8'h35, 8'hFF};
    ws_start = m_ws;
    idx = 0;
    run = 0;
    maxrun = 0;
    take = 1'b0;
    in_valid = 1'b1;
    in_data  = wl[0];
    for (int c = 0; c < 32; c++) begin
      take = in_valid && rdy0;
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL b2b d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      run = v0 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (take) begin
        idx++;
        if (idx < 3) in_data = wl[idx];
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (maxrun != 24) begin
      errors++;
      $display("FAIL b2b valid_run got %0d exp 24", maxrun);
    end
    checks++;
    if (ws0 !== ws_start + 16'd3) begin
      errors++;
      $display("FAIL b2b words_sent got %0d exp %0d", ws0, ws_start + 16'd3);
    end
  endtask

  task automatic test_reset_mid_word();
    int resid;
    resid = 0;
    in_valid = 1'b1;
    in_data  = 8'hD4;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL midrst ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL midrst d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      if (c >= 3 && (v0 || v1)) resid++;
      if (c == 0) in_data = 8'h35;
      if (c == 1) in_valid = 1'b0;
      if (c == 2) res = 1'b0;
      if (c == 3) res = 1'b1;
    end
    checks++;
    if (resid != 0) begin
      errors++;
      $display("FAIL midrst residual got %0d exp 0", resid);
    end
    checks++;
    if ({ws0, ws1} !== 32'd0) begin
      errors++;
      $display("FAIL midrst words_sent got %h exp 0", {ws0, ws1});
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut0.words_sent = 16'hFFFF;
    force dut1.words_sent = 16'hFFFF;
    m_ws = 16'hFFFF;
    #1;
    release dut0.words_sent;
    release dut1.words_sent;
    checks++;
    if (ws0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap preload got %h exp ffff", ws0);
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      in_valid = 1'b0;
    end
    checks++;
    if ({ws0, ws1} !== 32'd0) begin
      errors++;
      $display("FAIL wrap words_sent got %h exp 0", {ws0, ws1});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 830; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL random d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      if (c < 800) begin
        in_valid = ($urandom_range(0, 99) < 65);
        in_data  = W'($urandom);
        res      = ($urandom_range(0, 199) != 0);
`ifdef SER_PAUSE_EN
        pause    = ($urandom_range(0, 9) == 0);
`endif
      end else begin
        in_valid = 1'b0;
        res      = 1'b1;
`ifdef SER_PAUSE_EN
        pause    = 1'b0;
`endif
      end
    end
  endtask

`ifdef SER_PAUSE_EN
  task automatic test_pause();
    logic [7:0]  cap;
    logic [15:0] ws_prev;
    int first_c, done_c, gaps;
    cap = '0;
    ws_prev = m_ws;
    first_c = -1;
    done_c = -1;
    gaps = 0;
    in_valid = 1'b1;
    in_data  = 8'hD4;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pause ctl t=%0t got %h exp %h", $time, obs, exp_vec());
      end
      if (d_known()) begin
        checks++;
        if ({d0, d1} !== exp_d()) begin
          errors++;
          $display("FAIL pause d_in t=%0t got %b exp %b", $time, {d0, d1}, exp_d());
        end
      end
      if (v0) begin
        cap = {cap[6:0], d0};
        if (first_c < 0) first_c = c;
      end else if (first_c >= 0 && done_c < 0 && c < 10) begin
        gaps++;
      end
      if (done_c < 0 && ws0 !== ws_prev) done_c = c;
      in_valid = 1'b0;
      pause = (c == 2 || c == 3);
    end
    checks++;
    if (cap !== 8'hD4) begin
      errors++;
      $display("FAIL pause bits got %h exp d4", cap);
    end
    checks++;
    if (gaps != 2) begin
      errors++;
      $display("FAIL pause gaps got %0d exp 2", gaps);
    end
    checks++;
    if (first_c != 0 || done_c - first_c != 10) begin
      errors++;
      $display("FAIL pause span got %0d..%0d exp 0..10", first_c, done_c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_word();
`ifdef SER_PAUSE_EN
    test_pause();
`endif
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
